// File: rtl/vram_paint_scheduler_if.sv
// Request handshakes and VRAM write-port bundle for vram_paint_scheduler.
// master: touch side drives paint/clear requests and observes the write port.
// slave: the scheduler, which grants requests and drives the write port.
interface vram_paint_scheduler_if #(
  parameter int DISPLAY_WIDTH  = 240,
  parameter int DISPLAY_HEIGHT = 320
);
  localparam int VRAM_L = DISPLAY_WIDTH * DISPLAY_HEIGHT;
  localparam int A_W    = $clog2(VRAM_L);
  localparam int X_W    = $clog2(DISPLAY_WIDTH);
  localparam int Y_W    = $clog2(DISPLAY_HEIGHT);

  logic           clear_req;
  logic           req0_valid;
  logic           req0_ready;
  logic [X_W-1:0] req0_x;
  logic [Y_W-1:0] req0_y;
  logic [15:0]    req0_color;
  logic           req1_valid;
  logic           req1_ready;
  logic [X_W-1:0] req1_x;
  logic [Y_W-1:0] req1_y;
  logic [15:0]    req1_color;
  logic           wr_ena;
  logic [A_W-1:0] wr_addr;
  logic [15:0]    wr_data;
  logic           busy;

  modport master (
    output clear_req,
    output req0_valid, req0_x, req0_y, req0_color,
    output req1_valid, req1_x, req1_y, req1_color,
    input  req0_ready, req1_ready,
    input  wr_ena, wr_addr, wr_data, busy
  );

  modport slave (
    input  clear_req,
    input  req0_valid, req0_x, req0_y, req0_color,
    input  req1_valid, req1_x, req1_y, req1_color,
    output req0_ready, req1_ready,
    output wr_ena, wr_addr, wr_data, busy
  );
endinterface

// File: rtl/vram_paint_scheduler.sv
// Sole writer of the VRAM: full-screen clear, then round-robin brush painting from two touch requesters.
// Latency: a transfer at edge E puts the first brush pixel on wr_* after E+1; one pixel per cycle, BRUSH^2 cycles.
// Backpressure: ready is granted only in idle with no pending clear; a waiting requester holds valid and its data.
module vram_paint_scheduler #(
  parameter int          DISPLAY_WIDTH  = 240,
  parameter int          DISPLAY_HEIGHT = 320,
  parameter int          BRUSH          = 3,
  parameter logic [15:0] CLEAR_COLOR    = 16'h000F
) (
  input logic                   clk,
  input logic                   rst,
  vram_paint_scheduler_if.slave bus
);
  localparam int VRAM_L = DISPLAY_WIDTH * DISPLAY_HEIGHT;
  localparam int A_W    = $clog2(VRAM_L);
  localparam int X_W    = $clog2(DISPLAY_WIDTH);
  localparam int Y_W    = $clog2(DISPLAY_HEIGHT);
  localparam int R      = (BRUSH - 1) / 2;
  // Brush offsets run -R..+R; two spare bits keep the sign and the +R compare safe.
  localparam int D_W    = $clog2(BRUSH) + 2;

  localparam logic signed [D_W-1:0] NEG_R     = D_W'(-R);
  localparam logic signed [D_W-1:0] POS_R     = D_W'(R);
  localparam logic signed [D_W-1:0] ONE       = D_W'(1);
  localparam logic [A_W-1:0]        LAST_ADDR = A_W'(VRAM_L - 1);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_PAINT} state_t;

  state_t                state;
  logic [A_W-1:0]        clr_cnt;
  logic                  clear_pending;
  logic                  last_grant;
  logic [X_W-1:0]        x_q;
  logic [Y_W-1:0]        y_q;
  logic [15:0]           color_q;
  logic signed [D_W-1:0] dx;
  logic signed [D_W-1:0] dy;
  logic                  wr_ena_q;
  logic [A_W-1:0]        wr_addr_q;
  logic [15:0]           wr_data_q;

  logic                  grant0;
  logic                  grant1;
  logic                  ready0;
  logic                  ready1;
  logic signed [X_W:0]   px;
  logic signed [Y_W:0]   py;
  logic                  in_bounds;
  logic [A_W-1:0]        pix_addr;

  // Round-robin grant: a lone requester wins, a tie goes to whoever was not served last.
  always_comb begin
    grant0 = bus.req0_valid && (!bus.req1_valid || last_grant);
    grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant);
    ready0 = (state == S_IDLE) && !clear_pending && grant0;
    ready1 = (state == S_IDLE) && !clear_pending && grant1;
  end

  // Current brush pixel in signed coordinates; negatives and overshoot fall out as out-of-bounds.
  always_comb begin
    px        = $signed({1'b0, x_q}) + (X_W+1)'(dx);
    py        = $signed({1'b0, y_q}) + (Y_W+1)'(dy);
    in_bounds = !px[X_W] && ($unsigned(px) < (X_W+1)'(DISPLAY_WIDTH)) &&
                !py[Y_W] && ($unsigned(py) < (Y_W+1)'(DISPLAY_HEIGHT));
    pix_addr  = A_W'(py[Y_W-1:0]) * A_W'(DISPLAY_WIDTH) + A_W'(px[X_W-1:0]);
  end

  // Scheduler FSM: clear sweep, request acceptance and brush raster, all write-port outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_CLEAR;
      clr_cnt       <= LAST_ADDR;
      clear_pending <= 1'b0;
      last_grant    <= 1'b1;
      x_q           <= '0;
      y_q           <= '0;
      color_q       <= '0;
      dx            <= '0;
      dy            <= '0;
      wr_ena_q      <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
    end else begin
      wr_ena_q <= 1'b0;
      // A clear request arriving while a sweep is already running adds nothing.
      if (bus.clear_req && state != S_CLEAR) clear_pending <= 1'b1;

      case (state)
        S_CLEAR: begin
          wr_ena_q  <= 1'b1;
          wr_addr_q <= clr_cnt;
          wr_data_q <= CLEAR_COLOR;
          clr_cnt   <= clr_cnt - 1'b1;
          if (clr_cnt == '0) begin
            state         <= S_IDLE;
            clear_pending <= 1'b0;
          end
        end

        S_IDLE: begin
          if (clear_pending) begin
            state   <= S_CLEAR;
            clr_cnt <= LAST_ADDR;
          end else if (ready0) begin
            x_q        <= bus.req0_x;
            y_q        <= bus.req0_y;
            color_q    <= bus.req0_color;
            last_grant <= 1'b0;
            dx         <= NEG_R;
            dy         <= NEG_R;
            state      <= S_PAINT;
          end else if (ready1) begin
            x_q        <= bus.req1_x;
            y_q        <= bus.req1_y;
            color_q    <= bus.req1_color;
            last_grant <= 1'b1;
            dx         <= NEG_R;
            dy         <= NEG_R;
            state      <= S_PAINT;
          end
        end

        S_PAINT: begin
          // Clipped pixels still take their cycle so the paint time is fixed.
          if (in_bounds) begin
            wr_ena_q  <= 1'b1;
            wr_addr_q <= pix_addr;
            wr_data_q <= color_q;
          end
          if (dx == POS_R) begin
            dx <= NEG_R;
            if (dy == POS_R) state <= S_IDLE;
            else             dy    <= dy + ONE;
          end else begin
            dx <= dx + ONE;
          end
        end

        default: state <= S_CLEAR;
      endcase
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.wr_ena     = wr_ena_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.busy       = (state != S_IDLE);
endmodule

// File: tb/tb_vram_paint_scheduler.sv
// Bench for vram_paint_scheduler: 240-pixel rows with a 32-row screen so each full clear stays short.
// Brush paints come from a vector table; clears, arbitration and reset/clear interactions are hand sequences.
module tb_vram_paint_scheduler;
  localparam int          W   = 240;
  localparam int          H   = 32;
  localparam int          VL  = W * H;
  localparam int          A_W = $clog2(VL);
  localparam logic [15:0] CLR = 16'h000F;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  vram_paint_scheduler_if #(.DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H)) bus ();

  vram_paint_scheduler #(
    .DISPLAY_WIDTH (W),
    .DISPLAY_HEIGHT(H),
    .BRUSH         (3),
    .CLEAR_COLOR   (16'h000F)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               sel;
    int               x;
    int               y;
    logic [15:0]      color;
    int               n;
    logic [0:8][15:0] addr;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int sel, input int x, input int y, input logic [15:0] c, input int n,
                              input int a0, input int a1, input int a2, input int a3, input int a4,
                              input int a5, input int a6, input int a7, input int a8);
    vec_t v;
    v.sel = sel; v.x = x; v.y = y; v.color = c; v.n = n;
    v.addr[0] = 16'(a0); v.addr[1] = 16'(a1); v.addr[2] = 16'(a2);
    v.addr[3] = 16'(a3); v.addr[4] = 16'(a4); v.addr[5] = 16'(a5);
    v.addr[6] = 16'(a6); v.addr[7] = 16'(a7); v.addr[8] = 16'(a8);
    return v;
  endfunction

  // Expects the next edge to issue the first clear write; checks VL descending writes.
  task automatic check_clear(input string name, input int pulse_at);
    int bad = 0;
    int first = -1;
    logic [A_W-1:0] ea;
    for (int j = 0; j < VL; j++) begin
      @(negedge clk);
      bus.clear_req = (j == pulse_at);
      ea = A_W'(VL - 1 - j);
      if (bus.wr_ena !== 1'b1 || bus.wr_addr !== ea || bus.wr_data !== CLR) begin
        bad++;
        if (first < 0) first = j;
      end
    end
    bus.clear_req = 1'b0;
    check($sformatf("%s_bad_writes_first_at_%0d", name, first), bad, 0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int t = 0;
    int nb = 0;
    int nw = 0;
    logic rdy;
    @(negedge clk);
    if (v.sel == 0) begin
      bus.req0_valid = 1'b1; bus.req0_x = v.x[7:0]; bus.req0_y = v.y[4:0]; bus.req0_color = v.color;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_x = v.x[7:0]; bus.req1_y = v.y[4:0]; bus.req1_color = v.color;
    end
    #1;
    rdy = (v.sel == 0) ? bus.req0_ready : bus.req1_ready;
    while (!rdy && t < 50) begin
      @(negedge clk);
      t++;
      rdy = (v.sel == 0) ? bus.req0_ready : bus.req1_ready;
    end
    check($sformatf("v%0d_ready", idx), rdy, 1);
    check($sformatf("v%0d_other_ready", idx), (v.sel == 0) ? bus.req1_ready : bus.req0_ready, 0);
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      if (i <= 9 && bus.busy) nb++;
      if (i == 0) check($sformatf("v%0d_ready_dropped", idx), bus.req0_ready | bus.req1_ready, 0);
      if (i >= 1 && bus.wr_ena) begin
        if (nw < v.n) begin
          check($sformatf("v%0d_addr%0d", idx, nw), 32'(bus.wr_addr), 32'(v.addr[nw]));
          check($sformatf("v%0d_data%0d", idx, nw), 32'(bus.wr_data), 32'(v.color));
        end
        nw++;
      end
    end
    check($sformatf("v%0d_write_count", idx), nw, v.n);
    check($sformatf("v%0d_busy_cycles", idx), nb, 9);
  endtask

  task automatic arb(input string nm, input logic v0, input logic v1, input int nexp, input logic [3:0] seq);
    int ng = 0;
    int last_c = 0;
    int both = 0;
    @(negedge clk);
    bus.req0_valid = v0; bus.req0_x = 8'd50; bus.req0_y = 5'd5; bus.req0_color = 16'h1111;
    bus.req1_valid = v1; bus.req1_x = 8'd60; bus.req1_y = 5'd6; bus.req1_color = 16'h2222;
    #1;
    for (int c = 0; c < 100 && ng < nexp; c++) begin
      if (c > 0) @(negedge clk);
      if (bus.req0_ready && bus.req1_ready) both++;
      if (bus.req0_ready || bus.req1_ready) begin
        check($sformatf("%s_grant%0d_is_req1", nm, ng), bus.req1_ready, seq[ng]);
        if (ng > 0) check($sformatf("%s_spacing%0d", nm, ng), c - last_c, 10);
        last_c = c;
        ng++;
      end
    end
    check($sformatf("%s_grant_count", nm), ng, nexp);
    check($sformatf("%s_both_ready_cycles", nm), both, 0);
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    int t;
    int nw;
    logic found;

    vecs[0] = mk(0, 10, 20, 16'hF81F, 9, 4569, 4570, 4571, 4809, 4810, 4811, 5049, 5050, 5051);
    vecs[1] = mk(1, 0, 0, 16'h07E0, 4, 0, 1, 240, 241, 0, 0, 0, 0, 0);
    vecs[2] = mk(0, 239, 31, 16'h001F, 4, 7438, 7439, 7678, 7679, 0, 0, 0, 0, 0);
    vecs[3] = mk(1, 241, 5, 16'hFFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[4] = mk(0, 239, 0, 16'hABCD, 4, 238, 239, 478, 479, 0, 0, 0, 0, 0);
    vecs[5] = mk(1, 0, 31, 16'h5555, 4, 7200, 7201, 7440, 7441, 0, 0, 0, 0, 0);

    bus.clear_req  = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_x = '0; bus.req0_y = '0; bus.req0_color = '0;
    bus.req1_valid = 1'b0;
    bus.req1_x = '0; bus.req1_y = '0; bus.req1_color = '0;

    // Reset state, including a request that must not be granted during reset.
    repeat (3) @(negedge clk);
    check("rst_wr_ena", bus.wr_ena, 0);
    check("rst_wr_addr", 32'(bus.wr_addr), 0);
    check("rst_wr_data", 32'(bus.wr_data), 0);
    check("rst_busy", bus.busy, 1);
    check("rst_ready0", bus.req0_ready, 0);
    bus.req0_valid = 1'b0;
    rst = 1'b0;
    check_clear("reset_clear", -1);
    check("reset_clear_busy_low", bus.busy, 0);
    @(negedge clk);
    check("after_clear_wr_ena", bus.wr_ena, 0);
    check("after_clear_busy", bus.busy, 0);

    // Tie-breaking right after reset starts with req0, then alternates.
    arb("arb_both", 1'b1, 1'b1, 4, 4'b1010);
    arb("arb_req1_only", 1'b0, 1'b1, 3, 4'b0111);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Clear requested mid-paint while req0 keeps asking: paint, one idle cycle, clear, then req0.
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_x = 8'd10; bus.req0_y = 5'd20; bus.req0_color = 16'h1234;
    #1;
    t = 0;
    while (!bus.req0_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("cdp_first_ready", bus.req0_ready, 1);
    @(posedge clk);
    #1;
    nw = 0;
    for (int i = 0; i <= 9; i++) begin
      @(negedge clk);
      bus.clear_req = (i == 3);
      if (i >= 1 && bus.wr_ena) nw++;
    end
    check("cdp_paint_writes", nw, 9);
    check("cdp_idle_busy", bus.busy, 0);
    check("cdp_idle_ready_blocked", bus.req0_ready, 0);
    @(negedge clk);
    check("cdp_gap_wr_ena", bus.wr_ena, 0);
    check("cdp_gap_ready", bus.req0_ready, 0);
    check("cdp_gap_busy", bus.busy, 1);
    check_clear("cdp_clear", -1);
    check("cdp_req0_after_clear", bus.req0_ready, 1);
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    repeat (12) @(negedge clk);

    // Reset in the middle of a clear restarts it from the top; a clear_req during the sweep is dropped.
    bus.clear_req = 1'b1;
    @(negedge clk);
    bus.clear_req = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10000 && !found; k++) begin
      @(negedge clk);
      if (bus.wr_ena && bus.wr_addr == A_W'(4000)) found = 1'b1;
    end
    check("midclear_reached_4000", found, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midclear_rst_wr_ena", bus.wr_ena, 0);
    check("midclear_rst_busy", bus.busy, 1);
    rst = 1'b0;
    check_clear("restart_clear", 100);
    repeat (3) @(negedge clk);
    check("clear_req_in_clear_ignored_busy", bus.busy, 0);
    check("clear_req_in_clear_ignored_wr", bus.wr_ena, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
